// File: rtl/dm_ctrl_pkg.sv
// Shared types for the data-memory stage: DMType codes, access
// descriptor, and the DMType decoder (size + signedness).
package dm_ctrl_pkg;

  localparam logic [2:0] DM_WORD  = 3'b000;
  localparam logic [2:0] DM_HALF  = 3'b001;
  localparam logic [2:0] DM_HALFU = 3'b010;
  localparam logic [2:0] DM_BYTE  = 3'b011;
  localparam logic [2:0] DM_BYTEU = 3'b100;

  typedef enum logic [1:0] {
    SZ_WORD,
    SZ_HALF,
    SZ_BYTE
  } dm_size_e;

  typedef struct packed {
    dm_size_e size;
    logic     sign;
  } dm_acc_t;

  // Undefined codes fall back to a plain word access.
  function automatic dm_acc_t dm_decode(input logic [2:0] t);
    dm_acc_t a;
    a.size = SZ_WORD;
    a.sign = 1'b0;
    unique case (t)
      DM_HALF:  begin a.size = SZ_HALF; a.sign = 1'b1; end
      DM_HALFU: begin a.size = SZ_HALF; a.sign = 1'b0; end
      DM_BYTE:  begin a.size = SZ_BYTE; a.sign = 1'b1; end
      DM_BYTEU: begin a.size = SZ_BYTE; a.sign = 1'b0; end
      default:  ;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Byte-lane steering: merges store data into the old word and
// selects/extends the load lane.
// Ports: acc (size/sign), off (addr[1:0]), rword (RAM word),
//        wdata (right-aligned store data), wword (merged), ldata.
module dm_lane
  import dm_ctrl_pkg::*;
(
  input  dm_acc_t     acc,
  input  logic [1:0]  off,
  input  logic [31:0] rword,
  input  logic [31:0] wdata,
  output logic [31:0] wword,
  output logic [31:0] ldata
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  assign b_sel = rword[{off, 3'b000} +: 8];
  assign h_sel = rword[{off[1], 4'b0000} +: 16];

  always_comb begin
    wword = rword;
    ldata = rword;
    unique case (acc.size)
      SZ_BYTE: begin
        wword[{off, 3'b000} +: 8] = wdata[7:0];
        ldata = {{24{acc.sign & b_sel[7]}}, b_sel};
      end
      SZ_HALF: begin
        wword[{off[1], 4'b0000} +: 16] = wdata[15:0];
        ldata = {{16{acc.sign & h_sel[15]}}, h_sel};
      end
      default: begin
        wword = wdata;
        ldata = rword;
      end
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory stage: word RAM with lane steering, misalign reject
// and a wait-state FSM that stalls the pipeline for LAT cycles.
// Ports: clk, rst_n, mem_w, mem_r, DMType, addr, wdata -> rdata,
//        mem_stall, misalign; dbg_idx -> dbg_word (debug peek).
module dm_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_w,
  input  logic                     mem_r,
  input  logic [2:0]               DMType,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     mem_stall,
  output logic                     misalign,
  input  logic [$clog2(DEPTH)-1:0] dbg_idx,
  output logic [31:0]              dbg_word
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LAT > 0) ? LAT - 1 : 0);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [31:0] ram [DEPTH];
  logic [AW-1:0] widx;
  logic [31:0] rword, wword, ldata;
  dm_acc_t     acc;
  logic        act, bad, done, we;
  logic        unused_addr;

  assign widx        = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];
  assign acc         = dm_decode(DMType);
  assign rword       = ram[widx];
  assign dbg_word    = ram[dbg_idx];

  // Requests seen while reset is held must not stall or complete.
  assign act = (mem_w | mem_r) & rst_n;
  assign bad = ((acc.size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
               ((acc.size == SZ_HALF) && addr[0]);

  dm_lane u_lane (
    .acc   (acc),
    .off   (addr[1:0]),
    .rword (rword),
    .wdata (wdata),
    .wword (wword),
    .ldata (ldata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_stall = 1'b0;
    misalign  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (act) begin
          if (bad) begin
            misalign = 1'b1;
          end else if (LAT == 0) begin
            done = 1'b1;
          end else begin
            mem_stall = 1'b1;
            state_d   = S_BUSY;
            cnt_d     = CNT_INIT;
          end
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) begin
          mem_stall = 1'b1;
          cnt_d     = cnt_q - 1'b1;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Store wins when both flags are raised.
  assign we    = done & mem_w & rst_n;
  assign rdata = (done && mem_r && !mem_w) ? ldata : '0;

  always_ff @(posedge clk) begin
    if (we) ram[widx] <= wword;
  end

endmodule
